// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control unit for a multicycle RISC-V style datapath. A small FSM walks
//   each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB), latching
//   the instruction class in DECODE so later states ignore the live opcode.
//
// Ports
//   clk, rst               : clock (rising edge) and async active-high reset
//   opcode[6:0]            : instruction[6:0] from the instruction register
//   imem_ready, dmem_ready : fetch / data access complete this cycle
//   stall                  : freeze the FSM and suppress all write strobes
//   imem_req, dmem_req     : memory request strobes
//   IRWrite .. ALUSrc      : datapath enables and selects
//   ALUOp[1:0]             : 00 add, 10 R-type funct, 11 I-type funct
//   pc_sel_jump            : next PC is the JALR target instead of PC+4
//   state[2:0]             : current FSM state encoding
//   instr_done             : one-cycle pulse when an instruction retires
//   halted                 : FSM is parked in HALT after an illegal opcode
//   instret[INSTRET_W-1:0] : retired-instruction counter, wraps

module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 stall,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic [1:0]           ALUOp,
  output logic                 pc_sel_jump,
  output logic [2:0]           state,
  output logic                 instr_done,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R       = 3'd0,
    C_IALU    = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_JALR    = 3'd4,
    C_ILLEGAL = 3'd5
  } class_e;

  state_e                 state_q, state_d;
  class_e                 cls_q, cls_d;
  class_e                 opcode_cls;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  // Classify the live opcode; only consulted while in DECODE.
  always_comb begin
    opcode_cls = C_ILLEGAL;
    case (opcode)
      7'b0110011: opcode_cls = C_R;
      7'b0010011: opcode_cls = C_IALU;
      7'b0000011: opcode_cls = C_LOAD;
      7'b0100011: opcode_cls = C_STORE;
      7'b1100111: opcode_cls = C_JALR;
      default:    opcode_cls = C_ILLEGAL;
    endcase
  end

  // State register, latched class and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILLEGAL;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic. stall holds every legal state; stray encodings
  // always fall into HALT regardless of stall.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_FETCH: begin
        if (!stall && imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!stall) begin
          cls_d   = opcode_cls;
          state_d = (opcode_cls == C_ILLEGAL) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
          else if (cls_q == C_ILLEGAL)             state_d = S_HALT;
          else                                     state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!stall && dmem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        if (!stall) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Output decode from the current state and latched class. Write strobes
  // are masked by stall afterwards; request and select lines are not, so the
  // datapath keeps steering the same operands while frozen. While rst is
  // high every output is held low, independent of the clock.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = 2'b00;
    pc_sel_jump = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
        end
        S_EXEC: begin
          case (cls_q)
            C_R:    ALUOp = 2'b10;
            C_IALU: begin ALUOp = 2'b11; ALUSrc = 1'b1; end
            C_LOAD, C_STORE, C_JALR: ALUSrc = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          ALUSrc   = 1'b1;
          MemRead  = (cls_q == C_LOAD);
          MemWrite = (cls_q == C_STORE);
          // A store retires straight out of MEM; it has no WB state.
          if (dmem_ready && cls_q == C_STORE) begin
            PCWrite    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          RegWrite    = 1'b1;
          PCWrite     = 1'b1;
          instr_done  = 1'b1;
          MemtoReg    = (cls_q == C_LOAD);
          // JALR writes PC+4 to rd while the ALU still forms the target.
          pc_sel_jump = (cls_q == C_JALR);
          ALUSrc      = (cls_q == C_JALR);
        end
        default: ;
      endcase
      if (stall) begin
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
      end
    end
  end

  // Retire counter follows the already stall-masked instr_done.
  always_comb begin
    instret_d = instret_q;
    if (instr_done) instret_d = instret_q + INSTRET_W'(1);
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded by
// a transaction-level model into the cycle-by-cycle inputs it needs and the
// outputs the controller must show, and a negedge compare process checks the
// DUT against that expectation every driven cycle. A few literal checks pin
// reset, halt, mid-instruction reset and counter wrap. The counter is built
// 4 bits wide so wrap-around is reached in a short run.
module tb_multicycle_ctrl;

  localparam int W = 4;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_JALR = 4, K_BAD = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   opcode = 7'd0;
  logic         imem_ready = 1'b0;
  logic         dmem_ready = 1'b0;
  logic         stall = 1'b0;
  logic         imem_req, dmem_req, IRWrite, PCWrite, RegWrite;
  logic         MemRead, MemWrite, MemtoReg, ALUSrc, pc_sel_jump;
  logic [1:0]   ALUOp;
  logic [2:0]   state;
  logic         instr_done, halted;
  logic [W-1:0] instret;

  multicycle_ctrl #(.INSTRET_W(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .pc_sel_jump(pc_sel_jump),
    .state(state), .instr_done(instr_done), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   state;
    logic         imem_req, dmem_req, ir_write, pc_write, reg_write;
    logic         mem_read, mem_write, mem_to_reg, alu_src;
    logic [1:0]   alu_op;
    logic         pc_sel_jump, instr_done, halted;
    logic [W-1:0] instret;
  } obs_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready, stall;
  } stim_t;

  obs_t  act;
  assign act = {state, imem_req, dmem_req, IRWrite, PCWrite, RegWrite,
                MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp, pc_sel_jump,
                instr_done, halted, instret};

  int    tests_run = 0;
  int    tests_failed = 0;
  int    cycle_no = 0;
  int    model_retired = 0;
  bit    exp_valid = 1'b0;
  obs_t  exp_cur;
  stim_t stim_q[$];
  obs_t  exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid)
      checkOutput($sformatf("cycle%0d", cycle_no), {11'd0, act}, {11'd0, exp_cur});
  end

  function automatic int kind(input logic [6:0] opc);
    case (opc)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_JALR: return K_JALR;
      default: return K_BAD;
    endcase
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  // Record one cycle; the counter visible in a cycle is the number of
  // retirements before it, modulo 2^W.
  task automatic push(input logic [6:0] opc, input logic ir, input logic dr,
                      input logic st, input obs_t e);
    stim_t s;
    s.opcode = opc;
    s.imem_ready = ir;
    s.dmem_ready = dr;
    s.stall = st;
    e.instret = W'(model_retired);
    if (e.instr_done) model_retired = (model_retired + 1) % (1 << W);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Expand one instruction: fetch waits, fetch stalls (with ready high),
  // memory waits, memory stalls (with ready high) and writeback stalls.
  // With scramble set, the opcode turns illegal once DECODE is over.
  task automatic add_instr(input logic [6:0] opc, input int fw, input int fs,
                           input int mw, input int ms, input int ws,
                           input bit scramble);
    int         k;
    obs_t       e, m, w;
    logic [6:0] later;
    k = kind(opc);
    later = scramble ? OP_BAD : opc;
    repeat (fw) begin e = blank(3'd0); e.imem_req = 1; push(opc, 0, 0, 0, e); end
    repeat (fs) begin e = blank(3'd0); e.imem_req = 1; push(opc, 1, 0, 1, e); end
    e = blank(3'd0); e.imem_req = 1; e.ir_write = 1; push(opc, 1, 0, 0, e);
    e = blank(3'd1); push(opc, 1, 1, 0, e);
    if (k == K_BAD) return;
    e = blank(3'd2);
    if (k == K_R)      e.alu_op = 2'b10;
    else if (k == K_I) begin e.alu_op = 2'b11; e.alu_src = 1; end
    else               e.alu_src = 1;
    push(later, 0, 0, 0, e);
    if (k == K_LD || k == K_ST) begin
      m = blank(3'd3); m.dmem_req = 1; m.alu_src = 1;
      m.mem_read = (k == K_LD); m.mem_write = (k == K_ST);
      repeat (mw) push(later, 0, 0, 0, m);
      repeat (ms) begin e = m; e.mem_write = 0; push(later, 0, 1, 1, e); end
      e = m;
      if (k == K_ST) begin e.pc_write = 1; e.instr_done = 1; end
      push(later, 0, 1, 0, e);
    end
    if (k != K_ST) begin
      w = blank(3'd4);
      w.mem_to_reg = (k == K_LD);
      w.pc_sel_jump = (k == K_JALR);
      w.alu_src = (k == K_JALR);
      repeat (ws) push(later, 0, 0, 1, w);
      e = w; e.reg_write = 1; e.pc_write = 1; e.instr_done = 1;
      push(later, 0, 0, 0, e);
    end
  endtask

  task automatic add_halt(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(3'd7); e.halted = 1;
      push(OP_R, 1, 1, logic'(i % 2), e);
    end
  endtask

  task automatic idle();
    opcode = 7'd0; imem_ready = 0; dmem_ready = 0; stall = 0;
  endtask

  task automatic applyStimulus();
    stim_t s;
    obs_t  e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk); #1;
      opcode = s.opcode; imem_ready = s.imem_ready;
      dmem_ready = s.dmem_ready; stall = s.stall;
      exp_cur = e; exp_valid = 1'b1; cycle_no++;
    end
    @(negedge clk); #1;
    exp_valid = 1'b0;
  endtask

  initial begin
    obs_t e;
    #12;
    checkOutput("reset_outputs", {11'd0, act}, 32'd0);
    @(negedge clk); rst = 0; model_retired = 0;

    // Mixed program: plain ops, waits, stalls, opcode changing after DECODE.
    add_instr(OP_R,    0, 0, 0, 0, 0, 0);
    add_instr(OP_I,    0, 0, 0, 0, 0, 1);
    add_instr(OP_JALR, 0, 0, 0, 0, 0, 1);
    add_instr(OP_LD,   0, 0, 3, 0, 0, 1);
    add_instr(OP_ST,   0, 0, 2, 1, 0, 1);
    add_instr(OP_R,    2, 2, 0, 0, 0, 0);
    add_instr(OP_I,    0, 0, 0, 0, 1, 0);
    add_instr(OP_LD,   1, 0, 0, 1, 1, 1);
    applyStimulus();
    @(posedge clk); #1; idle();
    checkOutput("instret_after_program", 32'(instret), 32'd8);

    // Store parked in MEM, then reset asserted between clock edges.
    e = blank(3'd0); e.imem_req = 1; e.ir_write = 1; push(OP_ST, 1, 0, 0, e);
    e = blank(3'd1); push(OP_ST, 0, 0, 0, e);
    e = blank(3'd2); e.alu_src = 1; push(OP_ST, 0, 0, 0, e);
    e = blank(3'd3); e.dmem_req = 1; e.alu_src = 1; e.mem_write = 1;
    push(OP_ST, 0, 0, 0, e);
    applyStimulus();
    @(posedge clk); #1; opcode = OP_ST; dmem_ready = 0; stall = 0;
    checkOutput("mem_write_before_rst", 32'(MemWrite), 32'd1);
    #2 rst = 1;
    #1 checkOutput("mid_mem_reset", {11'd0, act}, 32'd0);
    @(negedge clk); rst = 0; idle(); model_retired = 0;

    // One retire, then an illegal opcode that must park the FSM in HALT.
    add_instr(OP_R, 0, 0, 0, 0, 0, 0);
    add_instr(OP_BAD, 0, 0, 0, 0, 0, 0);
    add_halt(4);
    applyStimulus();
    checkOutput("halted_flag", 32'(halted), 32'd1);
    checkOutput("instret_frozen", 32'(instret), 32'd1);
    rst = 1;
    #1 checkOutput("rst_exits_halt", {24'd0, state, halted, instret}, 32'd0);
    @(negedge clk); rst = 0; idle(); model_retired = 0;

    // Sixteen retirements bring the 4-bit counter back round to zero.
    for (int i = 0; i < 16; i++) add_instr((i % 2 == 0) ? OP_R : OP_I, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    @(posedge clk); #1; idle();
    checkOutput("instret_wrap", 32'(instret), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter INSTRET_W, default 32, meaning width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port opcode, input, 7, instruction[6:0] from the instruction register.
REQ-005 The block SHALL have port imem_ready, input, 1, instruction fetch complete this cycle.
REQ-006 The block SHALL have port dmem_ready, input, 1, data access complete this cycle.
REQ-007 The block SHALL have port stall, input, 1, freezes the FSM in its current state.
REQ-008 The block SHALL have ports imem_req and dmem_req, output, 1 each, memory request strobes.
REQ-009 The block SHALL have ports IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, output, 1 each, datapath enables and selects.
REQ-010 The block SHALL have port ALUOp, output, 2: 00 = add, 10 = R-type funct decode, 11 = I-type funct decode.
REQ-011 The block SHALL have port pc_sel_jump, output, 1: PC source is the JALR target (ALU result & ~1) rather than PC+4.
REQ-012 The block SHALL have ports state, output, 3; instr_done, output, 1; halted, output, 1; instret, output, INSTRET_W.

Function
REQ-013 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; codes 5 and 6 SHALL transition to HALT.
REQ-014 The opcode classes SHALL be: R=0110011, IALU=0010011, LOAD=0000011, STORE=0100011, JALR=1100111; every other opcode is ILLEGAL.
REQ-015 In DECODE, the class SHALL be latched into an internal register, and later states SHALL use only the latched class.
REQ-016 FETCH SHALL assert imem_req; on imem_ready it SHALL assert IRWrite for that cycle and move to DECODE, and otherwise remain in FETCH.
REQ-017 DECODE SHALL move to HALT if the class is ILLEGAL, and otherwise to EXEC, with no write enables asserted.
REQ-018 EXEC SHALL drive ALUOp/ALUSrc per class: R gives 10/0, IALU gives 11/1, LOAD/STORE/JALR give 00/1.
REQ-019 From EXEC, LOAD/STORE SHALL move to MEM, and R/IALU/JALR SHALL move to WB.
REQ-020 MEM SHALL assert dmem_req with ALUOp=00 and ALUSrc=1, plus MemRead for LOAD or MemWrite for STORE, holding these until dmem_ready.
REQ-021 On dmem_ready in MEM, LOAD SHALL move to WB; STORE SHALL assert PCWrite and instr_done and move to FETCH.
REQ-022 WB SHALL assert RegWrite, PCWrite, and instr_done, with MemtoReg=1 for LOAD and pc_sel_jump=1 for JALR (write data is PC+4), then move to FETCH; ALUOp/ALUSrc SHALL hold their EXEC values for JALR.
REQ-023 Outside the cases above, all enables and selects SHALL be 0 and ALUOp SHALL be 00.
REQ-024 With stall=1, the state SHALL be held and IRWrite, PCWrite, RegWrite, MemWrite, and instr_done SHALL be forced to 0; req/select outputs SHALL keep their state-decoded values.
REQ-025 stall SHALL take priority over imem_ready and dmem_ready in the same cycle; the ready is ignored and the handshake repeats.
REQ-026 HALT SHALL be absorbing: halted=1, all other outputs 0; only rst SHALL exit HALT.
REQ-027 instret SHALL increment by 1 on each cycle with instr_done=1 and SHALL wrap modulo 2^INSTRET_W.
REQ-028 Cycle counts without stalls or memory waits SHALL be: R/IALU/JALR 4 cycles, LOAD 5 cycles, STORE 4 cycles.
REQ-029 state SHALL equal the current state encoding.

Reset
REQ-030 While rst=1, the block SHALL force state=FETCH, latched class=ILLEGAL, instret=0, halted=0, and all enables/selects/ALUOp=0, independent of clk.
REQ-031 rst asserted mid-instruction (including during MEM with MemWrite=1) SHALL drop all enables immediately.
REQ-032 After rst deasserts, the first rising edge SHALL evaluate FETCH with imem_req=1.

Verification
REQ-033 R-type with imem_ready=dmem_ready=1 and stall=0 -> states 0,1,2,4 repeat; one RegWrite/PCWrite pulse in WB; instret increments by 1 every 4 cycles.
REQ-034 LOAD with dmem_ready low for 3 cycles -> MEM held 4 cycles with MemRead=1; then WB with MemtoReg=1; total 8 cycles.
REQ-035 JALR -> in WB, RegWrite=1, pc_sel_jump=1, PCWrite=1, ALUOp=00.
REQ-036 STORE -> MEM has MemWrite=1; no WB state; RegWrite never 1; instr_done pulses on the dmem_ready cycle.
REQ-037 opcode 0x7F -> DECODE then HALT; halted=1, instret frozen; rst returns to FETCH with instret=0.
REQ-038 stall=1 together with imem_ready=1 in FETCH -> no IRWrite, state stays 0; instret preloaded to 2^32-1 plus one retire -> 0.
